// File: rtl/loader_frame_parser.sv
// Configuration loader front end: parses 0xA5-framed write records from a byte
// stream into SELECT/ADDRESS/DATA tile writes, counting frames it has to drop.
module loader_frame_parser #(
  parameter int ADDRESS_SIZE = 10,
  parameter int DATA_SIZE    = 8,
  parameter int SEL_CYCLES   = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [7:0]              IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic                    SELECT,
  output logic [ADDRESS_SIZE-1:0] ADDRESS,
  output logic [DATA_SIZE-1:0]    DATA,
  output logic                    DONE,
  output logic [7:0]              ERR_COUNT
);
  // state     | meaning
  // S_HUNT    | idle; 0xA5 opens a write frame, 0x5A ends the stream, others dropped
  // S_ADDR_HI | capture address high byte
  // S_ADDR_LO | capture address low byte
  // S_DATA    | capture payload byte
  // S_CHK     | compare checksum and range; write or drop
  // S_WRITE   | SELECT high for SEL_CYCLES cycles
  // S_GAP     | one low cycle so back-to-back writes show a SELECT edge
  // S_END     | end of stream seen; parked until reset
  typedef enum logic [2:0] {
    S_HUNT, S_ADDR_HI, S_ADDR_LO, S_DATA, S_CHK, S_WRITE, S_GAP, S_END
  } state_t;

  localparam int              SC_W     = (SEL_CYCLES > 1) ? $clog2(SEL_CYCLES) : 1;
  localparam logic [SC_W-1:0] SEL_LOAD = SC_W'(SEL_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [7:0]              addr_hi_q, addr_hi_d;
  logic [7:0]              addr_lo_q, addr_lo_d;
  logic [7:0]              payload_q, payload_d;
  logic [ADDRESS_SIZE-1:0] address_q, address_d;
  logic [DATA_SIZE-1:0]    data_q, data_d;
  logic [SC_W-1:0]         sel_cnt_q, sel_cnt_d;
  logic [7:0]              err_cnt_q, err_cnt_d;

  logic [15:0] addr_word;
  logic        addr_ok;
  logic        chk_ok;
  logic        xfer;

  assign addr_word = {addr_hi_q, addr_lo_q};
  // Any address bit at or above ADDRESS_SIZE makes the frame unusable.
  assign addr_ok   = (addr_word >> ADDRESS_SIZE) == 16'd0;
  assign chk_ok    = IN_DATA == (addr_hi_q ^ addr_lo_q ^ payload_q);

  assign IN_READY  = !RESET && (state_q inside {S_HUNT, S_ADDR_HI, S_ADDR_LO, S_DATA, S_CHK});
  assign xfer      = IN_VALID && IN_READY;

  assign SELECT    = (state_q == S_WRITE);
  assign DONE      = (state_q == S_END);
  assign ADDRESS   = address_q;
  assign DATA      = data_q;
  assign ERR_COUNT = err_cnt_q;

  always_comb begin
    state_d   = state_q;
    addr_hi_d = addr_hi_q;
    addr_lo_d = addr_lo_q;
    payload_d = payload_q;
    address_d = address_q;
    data_d    = data_q;
    sel_cnt_d = sel_cnt_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      S_HUNT: begin
        if (xfer) begin
          if (IN_DATA == 8'hA5)      state_d = S_ADDR_HI;
          else if (IN_DATA == 8'h5A) state_d = S_END;
        end
      end
      S_ADDR_HI: begin
        if (xfer) begin
          addr_hi_d = IN_DATA;
          state_d   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        if (xfer) begin
          addr_lo_d = IN_DATA;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          payload_d = IN_DATA;
          state_d   = S_CHK;
        end
      end
      S_CHK: begin
        if (xfer) begin
          if (chk_ok && addr_ok) begin
            address_d = addr_word[ADDRESS_SIZE-1:0];
            data_d    = DATA_SIZE'(payload_q);
            sel_cnt_d = SEL_LOAD;
            state_d   = S_WRITE;
          end else begin
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            state_d = S_HUNT;
          end
        end
      end
      S_WRITE: begin
        if (sel_cnt_q == '0) state_d = S_GAP;
        else                 sel_cnt_d = sel_cnt_q - 1'b1;
      end
      S_GAP:   state_d = S_HUNT;
      S_END:   state_d = S_END;
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_HUNT;
      addr_hi_q <= '0;
      addr_lo_q <= '0;
      payload_q <= '0;
      address_q <= '0;
      data_q    <= '0;
      sel_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_hi_q <= addr_hi_d;
      addr_lo_q <= addr_lo_d;
      payload_q <= payload_d;
      address_q <= address_d;
      data_q    <= data_d;
      sel_cnt_q <= sel_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_loader_frame_parser.sv
// Bench for loader_frame_parser: directed frame sequences plus random payloads,
// checked against a frame-level reference model and a SELECT pulse monitor.
module tb_loader_frame_parser;
  localparam int AS = 10;
  localparam int DS = 8;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          select_o;
  logic [AS-1:0] address;
  logic [DS-1:0] data;
  logic          done;
  logic [7:0]    err_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // reference model state
  logic [7:0]    m_frame[$];
  logic          m_done;
  int            m_err;
  logic [AS-1:0] m_last_addr;
  logic [7:0]    m_last_data;
  logic [AS-1:0] exp_addr_q[$];
  logic [7:0]    exp_data_q[$];

  // monitor state
  logic          sel_prev = 1'b0;
  int            hi_run = 0;
  int            writes_seen = 0;
  logic [AS-1:0] mon_addr = '0;
  logic [7:0]    mon_data = '0;

  loader_frame_parser #(.ADDRESS_SIZE(AS), .DATA_SIZE(DS), .SEL_CYCLES(SC)) dut (
    .CLK(clk), .RESET(rst), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .SELECT(select_o), .ADDRESS(address), .DATA(data),
    .DONE(done), .ERR_COUNT(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_frame.delete();
    m_done = 1'b0;
    m_err = 0;
    m_last_addr = '0;
    m_last_data = '0;
    exp_addr_q.delete();
    exp_data_q.delete();
  endfunction

  // Frame-level view: collect a whole 5-byte record, then judge it.
  function automatic void model_byte(input logic [7:0] b);
    logic [15:0] word;
    if (m_frame.size() == 0) begin
      if (b == 8'hA5)      m_frame.push_back(b);
      else if (b == 8'h5A) m_done = 1'b1;
    end else begin
      m_frame.push_back(b);
      if (m_frame.size() == 5) begin
        word = {m_frame[1], m_frame[2]};
        if ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) == m_frame[4] && int'(word) < (1 << AS)) begin
          m_last_addr = word[AS-1:0];
          m_last_data = m_frame[3];
          exp_addr_q.push_back(word[AS-1:0]);
          exp_data_q.push_back(m_frame[3]);
        end else if (m_err < 255) begin
          m_err++;
        end
        m_frame.delete();
      end
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      sel_prev = 1'b0;
      hi_run = 0;
      mon_addr = '0;
      mon_data = '0;
    end else begin
      check("sel_with_ready", 32'(select_o & in_ready), 32'd0);
      if (select_o && !sel_prev) begin
        writes_seen++;
        hi_run = 1;
        check("write_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          mon_addr = exp_addr_q.pop_front();
          mon_data = exp_data_q.pop_front();
        end
        check("write_addr", 32'(address), 32'(mon_addr));
        check("write_data", 32'(data), 32'(mon_data));
      end else if (select_o) begin
        hi_run++;
        check("addr_hold", 32'(address), 32'(mon_addr));
        check("data_hold", 32'(data), 32'(mon_data));
      end else if (sel_prev) begin
        check("sel_width", 32'(hi_run), 32'(SC));
      end
      sel_prev = select_o;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int budget;
    if (stall) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        in_data = 8'($urandom);
        @(negedge clk);
      end
    end
    in_data = b;
    in_valid = 1'b1;
    budget = 50;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    model_byte(b);
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo,
                            input logic [7:0] d, input logic [7:0] chk, input bit stall);
    send_byte(8'hA5, stall);
    send_byte(hi, stall);
    send_byte(lo, stall);
    send_byte(d, stall);
    send_byte(chk, stall);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    @(negedge clk);
    check("rst_select", 32'(select_o), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(address), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(in_ready), 32'd1);
  endtask

  task automatic random_good(output logic [7:0] hi, output logic [7:0] lo,
                             output logic [7:0] d, output logic [7:0] chk);
    logic [15:0] w;
    w = 16'($urandom_range(0, (1 << AS) - 1));
    hi = w[15:8];
    lo = w[7:0];
    d = 8'($urandom);
    chk = hi ^ lo ^ d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] hi, lo, d, chk;
    int w0, t1, t2;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    model_reset();
    do_reset();

    // basic write and its exact timing
    send_frame(8'h01, 8'h23, 8'h45, 8'h67, 1'b0);
    in_valid = 1'b0;
    check("t1_sel_first", 32'(select_o), 32'd1);
    check("t1_addr", 32'(address), 32'(m_last_addr));
    check("t1_data", 32'(data), 32'(m_last_data));
    for (int i = 1; i < SC; i++) begin
      @(negedge clk);
      check("t1_sel_hold", 32'(select_o), 32'd1);
      check("t1_ready_busy", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    check("t1_gap_sel", 32'(select_o), 32'd0);
    check("t1_gap_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t1_ready_back", 32'(in_ready), 32'd1);
    check("t1_err", 32'(err_count), 32'(m_err));

    // bad checksum then good frame
    send_frame(8'h01, 8'h23, 8'h45, 8'h00, 1'b0);
    in_valid = 1'b0;
    check("t2_ready_after_bad", 32'(in_ready), 32'd1);
    check("t2_err", 32'(err_count), 32'(m_err));
    check("t2_addr_kept", 32'(address), 32'(m_last_addr));
    send_frame(8'h00, 8'h10, 8'hAA, 8'hBA, 1'b0);
    in_valid = 1'b0;
    repeat (SC + 2) @(negedge clk);
    check("t2_addr", 32'(address), 32'(m_last_addr));
    check("t2_data", 32'(data), 32'(m_last_data));

    // out-of-range address
    send_frame(8'h04, 8'h00, 8'h11, 8'h15, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    check("t3_err", 32'(err_count), 32'(m_err));
    check("t3_addr_kept", 32'(address), 32'(m_last_addr));
    check("t3_ready", 32'(in_ready), 32'd1);

    // garbage plus stalled random frames
    for (int k = 0; k < 4; k++) begin
      w0 = writes_seen;
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h3C, 1'b1);
      repeat (3) begin
        d = 8'($urandom);
        if (d == 8'hA5 || d == 8'h5A) d = 8'h11;
        send_byte(d, 1'b1);
      end
      random_good(hi, lo, d, chk);
      send_frame(hi, lo, d, chk, 1'b1);
      in_valid = 1'b0;
      repeat (SC + 2) @(negedge clk);
      check("t4_one_write", 32'(writes_seen - w0), 32'd1);
      check("t4_addr", 32'(address), 32'(m_last_addr));
      check("t4_data", 32'(data), 32'(m_last_data));
      check("t4_err", 32'(err_count), 32'(m_err));
    end

    // back-to-back frames with IN_VALID held, then end of stream
    w0 = writes_seen;
    random_good(hi, lo, d, chk);
    send_byte(8'hA5, 1'b0);
    t1 = cyc;
    send_byte(hi, 1'b0); send_byte(lo, 1'b0); send_byte(d, 1'b0); send_byte(chk, 1'b0);
    random_good(hi, lo, d, chk);
    send_byte(8'hA5, 1'b0);
    t2 = cyc;
    send_byte(hi, 1'b0); send_byte(lo, 1'b0); send_byte(d, 1'b0); send_byte(chk, 1'b0);
    check("t5_frame_period", 32'(t2 - t1), 32'(5 + SC + 1));
    send_byte(8'h5A, 1'b0);
    check("t5_done", 32'(done), 32'(m_done));
    check("t5_ready_end", 32'(in_ready), 32'd0);
    in_data = 8'hA5;
    in_valid = 1'b1;
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    check("t5_writes", 32'(writes_seen - w0), 32'd2);
    check("t5_done_sticky", 32'(done), 32'd1);
    check("t5_ready_stuck", 32'(in_ready), 32'd0);
    check("t5_addr", 32'(address), 32'(m_last_addr));

    // saturation of the error counter (reset out of END first)
    do_reset();
    for (int i = 0; i < 256; i++) begin
      hi = 8'($urandom);
      lo = 8'($urandom);
      d = 8'($urandom);
      chk = hi ^ lo ^ d ^ 8'($urandom_range(1, 255));
      send_frame(hi, lo, d, chk, 1'b0);
      if (i == 253 || i == 254) check("t6_err_edge", 32'(err_count), 32'(m_err));
    end
    in_valid = 1'b0;
    check("t6_err_sat", 32'(err_count), 32'(m_err));
    check("t6_no_write_addr", 32'(address), 32'd0);

    // reset in the middle of a write
    random_good(hi, lo, d, chk);
    send_frame(hi, lo, d, chk, 1'b0);
    in_valid = 1'b0;
    check("t7_sel_up", 32'(select_o), 32'd1);
    repeat (SC - 1) @(negedge clk);
    do_reset();
    w0 = writes_seen;
    random_good(hi, lo, d, chk);
    send_frame(hi, lo, d, chk, 1'b1);
    in_valid = 1'b0;
    repeat (SC + 2) @(negedge clk);
    check("t7_resume_write", 32'(writes_seen - w0), 32'd1);
    check("t7_addr", 32'(address), 32'(m_last_addr));
    check("t7_data", 32'(data), 32'(m_last_data));
    check("t7_err", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/loader_frame_parser.md
# loader_frame_parser

Upstream front end of the configuration loader. Accepts the configuration bitstream as a byte stream with a valid/ready handshake and parses it into write frames. For each good frame it drives one SELECT/ADDRESS/DATA write into the loader tile hierarchy. Frames with bad checksums or out-of-range addresses are dropped and counted, and an end-of-stream frame is flagged to the system controller.

## Interface
- ADDRESS_SIZE, 10, width of the configuration address sent to the tile hierarchy (legal range 1..16).
- DATA_SIZE, 8, configuration data width (fixed at 8, one payload byte per frame).
- SEL_CYCLES, 2, number of cycles SELECT is held high per write (≥1).
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  synchronous, active-high reset.
- IN_DATA  in  8  stream byte.
- IN_VALID  in  1  IN_DATA valid.
- IN_READY  out  1  parser can accept a byte this cycle.
- SELECT  out  1  write strobe to the top-level loader tile.
- ADDRESS  out  ADDRESS_SIZE  write address.
- DATA  out  DATA_SIZE  write data.
- DONE  out  1  end frame received; sticky.
- ERR_COUNT  out  8  dropped-frame counter; saturates at 255.

## Operation
- A byte transfers on a posedge where IN_VALID=1 and IN_READY=1; no other edge consumes a byte.
- Write frame is 5 bytes: 0xA5, ADDR_HI, ADDR_LO, DATA, CHK.
  - CHK = ADDR_HI ^ ADDR_LO ^ DATA.
  - Address = {ADDR_HI, ADDR_LO}[ADDRESS_SIZE-1:0].
- End frame is the single byte 0x5A.
- State machine:
  - HUNT: 0xA5 → ADDR_HI. 0x5A → END. Any other byte is discarded silently (no error).
  - ADDR_HI → ADDR_LO → DATA → CHK: each state stores one byte, then advances.
  - CHK: on a match with address in range → WRITE. On a mismatch, or any set bit of {ADDR_HI, ADDR_LO} at or above ADDRESS_SIZE → ERR_COUNT += 1 (saturating), return to HUNT; outputs unchanged.
  - WRITE: SELECT=1 for SEL_CYCLES cycles → GAP.
  - GAP: SELECT=0 for exactly 1 cycle → HUNT. Downstream tiles react to SELECT transitions, so consecutive writes always have a low gap.
  - END: DONE=1; stays in END until RESET.
- IN_READY=1 in HUNT, ADDR_HI, ADDR_LO, DATA, CHK. IN_READY=0 in WRITE, GAP, END.
- ADDRESS/DATA load on the edge that accepts a good CHK byte. They are held until the next good frame, and never change while SELECT=1.
- IN_VALID deasserting mid-frame stalls the parser in its current state; there is no timeout.
- A 0xA5 byte received mid-frame is treated as payload (no resync). Only checksum failure causes a resync.

## Timing
- Reset values: IN_READY=0 during reset and 1 on the first cycle after reset deasserts (HUNT); SELECT=0, ADDRESS=0, DATA=0, DONE=0, ERR_COUNT=0; state=HUNT.
- Good CHK accepted at edge N:
  - ADDRESS/DATA valid and SELECT=1 from N+1.
  - SELECT=0 from N+1+SEL_CYCLES (GAP).
  - IN_READY=1 from N+2+SEL_CYCLES.
- Back-to-back good frames with IN_VALID held high: 5 + SEL_CYCLES + 1 cycles per frame (8 at default).
- Bad CHK accepted at edge N: ERR_COUNT updated at N+1; IN_READY stays 1; the next byte may be accepted at N+1 in HUNT.
- 0x5A accepted at edge N in HUNT: DONE=1 and IN_READY=0 from N+1.
- RESET asserted in any state, including mid-frame, mid-WRITE, or END, takes effect at that edge:
  - SELECT drops the next cycle.
  - The partial frame is lost.
  - DONE and ERR_COUNT are cleared.
- Only one state action per cycle, so simultaneous events do not arise. The IN_VALID=1/IN_READY=0 case is simply not a transfer.

## Test plan
- Reset then stream A5 01 23 45 67 with IN_VALID high (ADDRESS_SIZE=10, CHK=01^23^45=67) → SELECT high for 2 cycles starting the cycle after CHK; ADDRESS=0x123, DATA=0x45; 1-cycle gap; IN_READY back high; ERR_COUNT=0.
- Bad checksum A5 01 23 45 00, then the good frame A5 00 10 AA BA → the first frame drops with no SELECT and ERR_COUNT=1; the second writes ADDRESS=0x010, DATA=0xAA.
- Out-of-range address A5 04 00 11 15 with ADDRESS_SIZE=10 → dropped, ERR_COUNT increments, no SELECT, ADDRESS unchanged.
- Leading garbage 00 FF 3C, then a good frame, with IN_VALID toggled randomly mid-frame → garbage discarded without error; exactly one write with correct values; SELECT never high while IN_READY=1.
- Two back-to-back good frames, then 5A → two SELECT pulses separated by a ≥1-cycle low; DONE=1 and IN_READY=0 after 5A; further bytes are ignored.
- 256 bad frames → ERR_COUNT saturates at 255. Then assert RESET during the WRITE of a good frame → SELECT=0, ERR_COUNT=0, DONE=0 the cycle after the reset edge; the parser resumes in HUNT.
